muxn_reg_scan: RTL and testbench
================================

# muxn_reg_scan

Parametrised N-input registered selector for the datapath: `INPUTS` channels of `BITS` each, one channel captured per accepted cycle into an output register with valid/ready handshake. It generalises the 2:1 registered mux to N inputs and adds an auto-scan mode, where an internal counter walks the channels round-robin. It sits between the per-channel source registers and any downstream consumer that can stall.

## Interface
- `BITS`, 3, data width per channel.
- `INPUTS`, 4, channel count; power of two, ≥2.
- `SEL_W`, $clog2(INPUTS), select/counter width (derived, not overridden).

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `enable`  in  1  capture request.
- `mode`  in  1  0 = direct (use `select`), 1 = scan (use internal counter).
- `select`  in  SEL_W  channel index in direct mode.
- `in_bus`  in  INPUTS*BITS  flattened channels; channel k = `in_bus[k*BITS +: BITS]`.
- `out`  out  BITS  captured data.
- `out_sel`  out  SEL_W  index of the channel held in `out`.
- `out_valid`  out  1  `out` holds unconsumed data.
- `out_ready`  in  1  downstream accepts `out` this cycle.
- `out_wrap`  out  1  held word is channel INPUTS-1 captured in scan mode.

## Operation
- Reset (reset=0, any time, async): `out`=0, `out_sel`=0, `out_valid`=0, `out_wrap`=0, scan counter `cnt`=0. Reset mid-transfer drops the held word; no partial state survives.
- `accept` = `enable` && (!`out_valid` || `out_ready`).
- Channel index `idx` = `mode` ? `cnt` : `select`.
- On accept: `out`←channel `idx`, `out_sel`←`idx`, `out_valid`←1, `out_wrap`←(`mode` && `idx`==INPUTS-1).
- Counter on accept: scan mode: `cnt`←`cnt`+1 modulo INPUTS (INPUTS-1 wraps to 0). Direct mode: `cnt`←`select`+1 modulo INPUTS, so a later switch to scan resumes after the last directly-selected channel.
- No accept and `out_ready`=1 with `out_valid`=1: `out_valid`←0, `out_wrap`←0; `out`/`out_sel` hold their values.
- No accept otherwise: all state holds; `cnt` never advances without accept.
- Simultaneous consume and capture (valid=1, ready=1, enable=1): old word consumed, new word loaded same edge, `out_valid` stays 1 — full throughput, one word per cycle.
- `mode` or `select` changing while stalled (valid=1, ready=0) has no effect until the next accept.
- Out-of-range `select` impossible (INPUTS is a power of two).

## Timing
- Latency 1 cycle: channel data and `select` sampled at edge k appear on `out` after edge k.
- All outputs are registered; none depend combinationally on inputs.
- `out_ready` is sampled only when `out_valid`=1; ready while not valid is ignored.
- Sustained throughput 1 word/cycle with `out_ready` held high. Under stall the held word is stable until the ready edge.

## Structure
- Shared header `mux_defs.vh`: `MODE_DIRECT`=1'b0 and `MODE_SCAN`=1'b1.
- Sub-module `muxn_cell`: 1-bit, INPUTS:1 combinational tree of 2:1 cells, log2(INPUTS) levels. Instantiate it BITS times via generate, one per output bit.
- Top level holds the handshake logic, counter and output registers.

## Test plan
- Reset: drive reset=0 mid-stream with out_valid=1 → all outputs 0 immediately (async), cnt=0. First scan accept after release captures channel 0.
- Direct mode, INPUTS=4, BITS=3, channels {0:3'd1,1:3'd2,2:3'd5,3:3'd7}, select=2, enable=1, ready=1 → out=5, out_sel=2, out_valid=1 one cycle later, out_wrap=0.
- Scan mode, enable=1, ready=1 for 6 cycles → out_sel 0,1,2,3,0,1, out = 1,2,5,7,1,2. out_wrap=1 only on the out_sel=3 cycle.
- Stall: out_valid=1, ready=0 for 3 cycles while enable=1 in scan mode → out/out_sel constant, cnt frozen. Then ready=1 → next channel captured, no skipped index.
- Mode handoff: direct select=1 accepted, then mode=scan → next captures are channels 2,3,0.
- Drain: enable=0, ready=1 with out_valid=1 → out_valid=0 next cycle and out unchanged. Ready asserted while out_valid=0 → no state change.

Source files
------------

// File: rtl/muxn_reg_scan_pkg.sv
// Shared definitions for the N-input registered selector: capture-mode encoding
// and the 2:1 cell used to build the selection tree.
package muxn_reg_scan_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic logic mux2(input logic sel, input logic a0, input logic a1);
        logic y;
        if (sel) begin
            y = a1;
        end else begin
            y = a0;
        end
        return y;
    endfunction

endpackage

// File: rtl/muxn_reg_scan_cell.sv
// One-bit INPUTS:1 selector built as a balanced tree of 2:1 cells; stage 0 is
// the raw inputs and each later stage halves the width using one select bit.
module muxn_cell
    import muxn_reg_scan_pkg::*;
#(
    parameter  int INPUTS = 4,
    localparam int SEL_W  = $clog2(INPUTS)
) (
    input  logic [INPUTS-1:0] din,
    input  logic [SEL_W-1:0]  sel,
    output logic              dout
);

    genvar s, j;
    generate
        for (s = 0; s <= SEL_W; s++) begin : g_stage
            logic [(INPUTS >> s)-1:0] node_s;
            if (s == 0) begin : g_leaf
                assign node_s = din;
            end else begin : g_mux
                // Neighbouring pairs differ in select bit s-1, so that bit picks the pair member.
                for (j = 0; j < (INPUTS >> s); j++) begin : g_node
                    assign node_s[j] = mux2(sel[s-1],
                                            g_stage[s-1].node_s[2*j],
                                            g_stage[s-1].node_s[2*j+1]);
                end
            end
        end
    endgenerate

    assign dout = g_stage[SEL_W].node_s[0];

endmodule

// File: rtl/muxn_reg_scan.sv
// Registered N:1 channel selector with valid/ready output handshake and a
// round-robin scan mode driven by an internal channel counter.
module muxn_reg_scan
    import muxn_reg_scan_pkg::*;
#(
    parameter  int BITS   = 3,
    parameter  int INPUTS = 4,
    localparam int SEL_W  = $clog2(INPUTS)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         select,
    input  logic [INPUTS*BITS-1:0]   in_bus,
    output logic [BITS-1:0]          out,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_wrap
);

    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(INPUTS - 1);

    logic [BITS-1:0]  out_r,       out_nxt_s;
    logic [SEL_W-1:0] out_sel_r,   out_sel_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic             out_wrap_r,  out_wrap_nxt_s;
    logic [SEL_W-1:0] cnt_r,       cnt_nxt_s;

    logic             accept_s;
    logic             scan_s;
    logic [SEL_W-1:0] idx_s;
    logic [BITS-1:0]  mux_s;

    // Channel index source: internal counter in scan mode, external select otherwise.
    always_comb begin
        scan_s = 1'b0;
        idx_s  = select;
        case (mode_e'(mode))
            MODE_SCAN: begin
                scan_s = 1'b1;
                idx_s  = cnt_r;
            end
            MODE_DIRECT: begin
                scan_s = 1'b0;
                idx_s  = select;
            end
            default: begin
                scan_s = 1'b0;
                idx_s  = select;
            end
        endcase
    end

    assign accept_s = enable && (!out_valid_r || out_ready);

    // One selection tree per data bit; column b gathers bit b of every channel.
    genvar b, k;
    generate
        for (b = 0; b < BITS; b++) begin : g_bit
            logic [INPUTS-1:0] col_s;
            for (k = 0; k < INPUTS; k++) begin : g_col
                assign col_s[k] = in_bus[k*BITS + b];
            end
            muxn_cell #(
                .INPUTS (INPUTS)
            ) u_cell (
                .din  (col_s),
                .sel  (idx_s),
                .dout (mux_s[b])
            );
        end
    endgenerate

    // Next-state: capture on accept, retire on consume, otherwise hold everything.
    always_comb begin
        out_nxt_s       = out_r;
        out_sel_nxt_s   = out_sel_r;
        out_valid_nxt_s = out_valid_r;
        out_wrap_nxt_s  = out_wrap_r;
        cnt_nxt_s       = cnt_r;
        if (accept_s) begin
            out_nxt_s       = mux_s;
            out_sel_nxt_s   = idx_s;
            out_valid_nxt_s = 1'b1;
            out_wrap_nxt_s  = scan_s && (idx_s == LAST_IDX);
            // Counter follows the captured channel so scan resumes after a direct pick.
            cnt_nxt_s       = idx_s + SEL_ONE;
        end else if (out_valid_r && out_ready) begin
            out_valid_nxt_s = 1'b0;
            out_wrap_nxt_s  = 1'b0;
        end else begin
            out_valid_nxt_s = out_valid_r;
            out_wrap_nxt_s  = out_wrap_r;
        end
    end

    // Output and counter registers; reset drops any held word.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_r       <= {BITS{1'b0}};
            out_sel_r   <= {SEL_W{1'b0}};
            out_valid_r <= 1'b0;
            out_wrap_r  <= 1'b0;
            cnt_r       <= {SEL_W{1'b0}};
        end else begin
            out_r       <= out_nxt_s;
            out_sel_r   <= out_sel_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_wrap_r  <= out_wrap_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    assign out       = out_r;
    assign out_sel   = out_sel_r;
    assign out_valid = out_valid_r;
    assign out_wrap  = out_wrap_r;

endmodule

// File: tb/tb_muxn_reg_scan.sv
// Self-checking bench for muxn_reg_scan: reference model plus a scoreboard of
// captured words that is checked whenever the consumer takes a word.
module tb_muxn_reg_scan;

    localparam int BITS   = 3;
    localparam int INPUTS = 4;
    localparam int SEL_W  = 2;
    localparam int WW     = BITS + SEL_W + 1;

    logic                   clock;
    logic                   reset;
    logic                   enable;
    logic                   mode;
    logic [SEL_W-1:0]       select;
    logic [INPUTS*BITS-1:0] in_bus;
    logic [BITS-1:0]        out;
    logic [SEL_W-1:0]       out_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic                   out_wrap;

    muxn_reg_scan #(
        .BITS   (BITS),
        .INPUTS (INPUTS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .mode      (mode),
        .select    (select),
        .in_bus    (in_bus),
        .out       (out),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_wrap  (out_wrap)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0]    sbq[$];
    logic [BITS-1:0]  m_data;
    logic [SEL_W-1:0] m_sel;
    logic             m_wrap;
    logic             m_valid;
    logic [SEL_W-1:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_sel   = '0;
        m_wrap  = 1'b0;
        m_valid = 1'b0;
        m_cnt   = '0;
        sbq.delete();
    endtask

    // Drive one cycle of stimulus, score a consumed word, advance the model, check after the edge.
    task automatic cycle(input logic en, input logic md, input logic [SEL_W-1:0] sl, input logic rdy);
        logic             acc;
        logic [SEL_W-1:0] idx;
        logic [BITS-1:0]  d;
        logic [WW-1:0]    w;
        enable    = en;
        mode      = md;
        select    = sl;
        out_ready = rdy;
        #1;
        if (m_valid && rdy) begin
            if (sbq.size() == 0) begin
                check("sb_nonempty", 32'(sbq.size()), 32'd1);
            end else begin
                w = sbq.pop_front();
                check("sb_word", {out, out_sel, out_wrap}, w);
            end
        end
        acc = en && (!m_valid || rdy);
        idx = md ? m_cnt : sl;
        d   = in_bus[idx*BITS +: BITS];
        if (acc) begin
            m_data  = d;
            m_sel   = idx;
            m_wrap  = md && (idx == 2'd3);
            m_valid = 1'b1;
            m_cnt   = idx + 2'd1;
            sbq.push_back({d, idx, m_wrap});
        end else if (rdy && m_valid) begin
            m_valid = 1'b0;
            m_wrap  = 1'b0;
        end
        @(posedge clock);
        #1;
        check("state", {out, out_sel, out_wrap, out_valid}, {m_data, m_sel, m_wrap, m_valid});
    endtask

    logic [SEL_W-1:0] seq_sel [6];
    logic [BITS-1:0]  seq_dat [6];
    logic [SEL_W-1:0] ho_sel  [3];

    initial begin
        seq_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq_dat = '{3'd1, 3'd2, 3'd5, 3'd7, 3'd1, 3'd2};
        ho_sel  = '{2'd2, 2'd3, 2'd0};
        reset     = 1'b0;
        enable    = 1'b0;
        mode      = 1'b0;
        select    = '0;
        out_ready = 1'b0;
        in_bus    = {3'd7, 3'd5, 3'd2, 3'd1};
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_out",   out,       3'd0);
        check("rst_sel",   out_sel,   2'd0);
        check("rst_valid", out_valid, 1'b0);
        check("rst_wrap",  out_wrap,  1'b0);
        reset = 1'b1;

        // Scan walk from counter 0, wrapping once.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 1'b1);
            check("scan_sel",  out_sel,  seq_sel[i]);
            check("scan_data", out,      seq_dat[i]);
            check("scan_wrap", out_wrap, seq_sel[i] == 2'd3);
        end

        // Direct select of channel 2.
        cycle(1'b1, 1'b0, 2'd2, 1'b1);
        check("dir_out",   out,       3'd5);
        check("dir_sel",   out_sel,   2'd2);
        check("dir_valid", out_valid, 1'b1);
        check("dir_wrap",  out_wrap,  1'b0);

        // Scan capture of channel 3, then stall with mode/select wiggling.
        cycle(1'b1, 1'b1, 2'd0, 1'b1);
        check("stall_pre", out_sel, 2'd3);
        cycle(1'b1, 1'b1, 2'd0, 1'b0);
        check("stall_out", out, 3'd7);
        cycle(1'b1, 1'b0, 2'd1, 1'b0);
        check("stall_sel", out_sel, 2'd3);
        cycle(1'b1, 1'b1, 2'd2, 1'b0);
        check("stall_hold", {out, out_sel}, {3'd7, 2'd3});
        cycle(1'b1, 1'b1, 2'd0, 1'b1);
        check("stall_next", out_sel, 2'd0);

        // Direct channel 1 then switch to scan: continues at 2,3,0.
        cycle(1'b1, 1'b0, 2'd1, 1'b1);
        check("ho_direct", out_sel, 2'd1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 2'd0, 1'b1);
            check("ho_scan", out_sel, ho_sel[i]);
        end

        // Drain, then ready with nothing held.
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        check("drain_valid", out_valid, 1'b0);
        check("drain_out",   out,       3'd1);
        cycle(1'b0, 1'b1, 2'd3, 1'b1);
        check("idle_ready", {out, out_sel, out_valid}, {3'd1, 2'd0, 1'b0});

        // Randomised traffic with changing channel data.
        for (int i = 0; i < 300; i++) begin
            in_bus = 12'($urandom);
            cycle(1'($urandom), 1'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset in mid-cycle while a word is held.
        in_bus = {3'd7, 3'd5, 3'd2, 3'd1};
        cycle(1'b1, 1'b0, 2'd3, 1'b1);
        check("mid_valid", out_valid, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_out",   out,       3'd0);
        check("arst_sel",   out_sel,   2'd0);
        check("arst_valid", out_valid, 1'b0);
        check("arst_wrap",  out_wrap,  1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(1'b1, 1'b1, 2'd2, 1'b1);
        check("arst_first", {out, out_sel}, {3'd1, 2'd0});

        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        cycle(1'b0, 1'b0, 2'd0, 1'b1);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
